// File: rtl/sample_collector_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sample_collector_if                                              |
// | Purpose : Poll bus, sample bus and host FIFO read path of sample_collector. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface sample_collector_if #(
    parameter int CNT_W = 5
);
    logic             enable;
    logic             output_sample;
    logic [7:0]       channel_select;
    logic [31:0]      sample_data;
    logic             fifo_rd;
    logic [39:0]      fifo_data;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    logic             clear_overflow;
    logic [15:0]      bad_count;

    // Collector side
    modport slave (
        input  enable, sample_data, fifo_rd, clear_overflow,
        output output_sample, channel_select, fifo_data, fifo_empty,
               fifo_count, overflow, bad_count
    );

    // Host / pin-controller side
    modport master (
        output enable, sample_data, fifo_rd, clear_overflow,
        input  output_sample, channel_select, fifo_data, fifo_empty,
               fifo_count, overflow, bad_count
    );
endinterface
`default_nettype wire

// File: rtl/sample_collector.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sample_collector                                                 |
// | Purpose : Round-robin polls pin controllers, keeps changed samples in FIFO. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sample_collector #(
    parameter int NUM_CHANNELS = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sample_collector_if.slave bus
);
    localparam int c_ch_iw = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int c_slots = 1 << c_ch_iw;
    localparam int c_aw    = $clog2(FIFO_DEPTH);

    localparam logic [7:0]  c_last_ch = 8'(NUM_CHANNELS - 1);
    // Marker field is word[15:1]; with the pin bit the low half reads 0x55E6/0x55E7.
    localparam logic [14:0] c_marker  = 15'h2AF3;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_cap  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [7:0]         ch_q, ch_d;
    logic               output_sample_q, output_sample_d;
    logic [7:0]         channel_select_q, channel_select_d;
    logic [c_slots-1:0] seen_q, seen_d;
    logic [14:0]        last_cnt_q [c_slots];
    logic [14:0]        last_cnt_d [c_slots];
    logic [39:0]        mem_q [FIFO_DEPTH];
    logic [39:0]        mem_d [FIFO_DEPTH];
    logic [c_aw-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        bad_count_q, bad_count_d;

    logic [c_ch_iw-1:0] w_ch_idx;
    logic [14:0]        w_cnt;
    logic               w_cap;
    logic               w_marker_ok;
    logic               w_changed;
    logic               w_push_req;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_drop;

    // Sample qualification and FIFO control
    always_comb begin
        w_ch_idx    = ch_q[c_ch_iw-1:0];
        w_cnt       = bus.sample_data[30:16];
        w_cap       = (state_q == c_st_cap);
        // An undriven (X/Z) bus falls into the else branch and is treated as bad.
        w_marker_ok = 1'b0;
        if (bus.sample_data[15:1] == c_marker) begin
            w_marker_ok = 1'b1;
        end
        w_changed   = !seen_q[w_ch_idx] || (last_cnt_q[w_ch_idx] != w_cnt);
        w_push_req  = w_cap && w_marker_ok && w_changed;
        w_full      = (count_q == CNT_W'(FIFO_DEPTH));
        w_empty     = (count_q == '0);
        w_pop       = bus.fifo_rd && !w_empty;
        w_push_ok   = w_push_req && (!w_full || w_pop);
        w_drop      = w_push_req && w_full && !w_pop;
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            c_st_idle: if (bus.enable) state_d = c_st_req;
            c_st_req:  state_d = c_st_wait;
            c_st_wait: state_d = c_st_cap;
            c_st_cap: begin
                ch_d    = (ch_q == c_last_ch) ? 8'd0 : ch_q + 8'd1;
                state_d = bus.enable ? c_st_req : c_st_idle;
            end
            default:   state_d = c_st_idle;
        endcase
        output_sample_d  = (state_d == c_st_req);
        channel_select_d = (state_d == c_st_req) ? ch_d : channel_select_q;
    end

    always_comb begin
        seen_d      = seen_q;
        last_cnt_d  = last_cnt_q;
        bad_count_d = bad_count_q;
        if (w_push_req) begin
            seen_d[w_ch_idx]     = 1'b1;
            last_cnt_d[w_ch_idx] = w_cnt;
        end
        if (w_cap && !w_marker_ok && (bad_count_q != 16'hFFFF)) begin
            bad_count_d = bad_count_q + 16'd1;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + c_aw'(w_push_ok);
        rd_ptr_d = rd_ptr_q + c_aw'(w_pop);
        count_d  = count_q;
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = {ch_q, bus.sample_data};
        end
        if (w_push_ok && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_push_ok && w_pop) begin
            count_d = count_q - CNT_W'(1);
        end
        // A same-cycle overflow event outranks the clear request.
        overflow_d = overflow_q;
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= c_st_idle;
            ch_q             <= '0;
            output_sample_q  <= 1'b0;
            channel_select_q <= '0;
            seen_q           <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            overflow_q       <= 1'b0;
            bad_count_q      <= '0;
        end else begin
            state_q          <= state_d;
            ch_q             <= ch_d;
            output_sample_q  <= output_sample_d;
            channel_select_q <= channel_select_d;
            seen_q           <= seen_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            overflow_q       <= overflow_d;
            bad_count_q      <= bad_count_d;
        end
    end

    // Storage needs no reset: seen_q and count_q gate every read of it.
    always_ff @(posedge clk) begin
        last_cnt_q <= last_cnt_d;
        mem_q      <= mem_d;
    end

    assign bus.output_sample  = output_sample_q;
    assign bus.channel_select = channel_select_q;
    assign bus.fifo_data      = w_empty ? 40'd0 : mem_q[rd_ptr_q];
    assign bus.fifo_empty     = w_empty;
    assign bus.fifo_count     = count_q;
    assign bus.overflow       = overflow_q;
    assign bus.bad_count      = bad_count_q;
endmodule
`default_nettype wire

// File: tb/tb_sample_collector.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sample_collector                                              |
// | Purpose : Random pin-controller model with scoreboard for sample_collector. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sample_collector;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 16;
    localparam int CW     = 5;
    localparam logic [14:0] MARK = 15'h2AF3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sample_collector_if #(.CNT_W(CW)) bus ();

    sample_collector #(
        .NUM_CHANNELS(NUM_CH),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          n_pop   = 0;
    int          cyc     = 0;
    int          bad_exp = 0;
    int          mode    = 0;   // 0 random words, 1 directed ch2 / others undriven, 2 always new
    bit          rd_en    = 1'b0;
    bit          rd_force = 1'b0;
    logic [39:0] exp_q [$];
    logic [31:0] dir_q [$];
    bit          m_seen [NUM_CH];
    logic [14:0] m_last [NUM_CH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] mk(input logic [14:0] cnt, input logic pin);
        return {1'b0, cnt, MARK, pin};
    endfunction

    // Pin-controller model plus reference rules for which words become FIFO entries
    initial begin : ctl
        logic [31:0] w;
        int          ch;
        int          r;
        bus.sample_data = '0;
        forever begin
            @(negedge clk);
            if (bus.output_sample === 1'b1) begin
                ch = int'(bus.channel_select);
                if (ch >= NUM_CH) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL poll_range: got channel %0d, expected < %0d", ch, NUM_CH);
                    ch = 0;
                end
                r = int'($urandom_range(0, 9));
                case (mode)
                    0: begin
                        if (r == 0) begin
                            w = 32'd0;
                        end else if (r == 1) begin
                            w = $urandom;
                            if (w[15:1] == MARK) w[1] = ~w[1];
                        end else if (r <= 3) begin
                            w = mk(m_seen[ch] ? m_last[ch] : 15'($urandom), 1'($urandom));
                        end else if (r == 4) begin
                            w = mk((m_seen[ch] && m_last[ch] == 15'h7FFF) ? 15'h0 : 15'h7FFF,
                                   1'($urandom));
                        end else begin
                            w = mk(15'($urandom), 1'($urandom));
                        end
                    end
                    1: w = (ch == 2 && dir_q.size() > 0) ? dir_q.pop_front() : 32'd0;
                    default: w = mk(m_seen[ch] ? m_last[ch] + 15'd1 : 15'($urandom), 1'($urandom));
                endcase
                bus.sample_data = w;
                if (w[15:1] != MARK) begin
                    bad_exp++;
                end else if (!m_seen[ch] || w[30:16] != m_last[ch]) begin
                    exp_q.push_back({8'(ch), w});
                    m_seen[ch] = 1'b1;
                    m_last[ch] = w[30:16];
                end
            end
        end
    end

    // Host reader
    initial begin
        bus.fifo_rd = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.fifo_rd = rd_force || (rd_en && ($urandom_range(0, 1) == 1));
        end
    end

    // Scoreboard monitor: every real pop is matched against the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus.fifo_rd && !bus.fifo_empty) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL fifo_pop: got 0x%0h, expected no entry", bus.fifo_data);
                end else begin
                    check("fifo_pop", 64'(bus.fifo_data), 64'(exp_q.pop_front()));
                end
                n_pop++;
            end
        end
    end

    task automatic wait_req(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (bus.output_sample === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no output_sample in 40 cycles, expected a strobe", name);
        end
    endtask

    task automatic quiesce();
        bus.enable = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            #3;
            if (exp_q.size() == 0 && bus.fifo_empty) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0d entries left, expected 0", name, exp_q.size());
        end
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int t_prev;
        int pop0;
        bus.enable         = 1'b0;
        bus.clear_overflow = 1'b0;
        for (int i = 0; i < NUM_CH; i++) m_seen[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_output_sample", 64'(bus.output_sample), 64'd0);
        check("rst_channel_select", 64'(bus.channel_select), 64'd0);
        check("rst_fifo_data", 64'(bus.fifo_data), 64'd0);
        check("rst_fifo_empty", 64'(bus.fifo_empty), 64'd1);
        check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_bad_count", 64'(bus.bad_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Scan order and strobe period
        rd_en      = 1'b1;
        bus.enable = 1'b1;
        t_prev     = 0;
        for (int i = 0; i < 5; i++) begin
            wait_req("scan_seq");
            check("scan_channel", 64'(bus.channel_select), 64'(i % NUM_CH));
            if (i > 0) check("scan_period", 64'(cyc - t_prev), 64'd3);
            t_prev = cyc;
        end

        // Random traffic with enable gaps
        for (int i = 0; i < 200; i++) begin
            wait_req("random");
            if ($urandom_range(0, 7) == 0) begin
                bus.enable = 1'b0;
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1;
                bus.enable = 1'b1;
            end
        end
        quiesce();
        drain("random_drain");
        check("rand_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("rand_fifo_empty", 64'(bus.fifo_empty), 64'd1);
        check("rand_overflow", 64'(bus.overflow), 64'd0);
        check("rand_bad_count", 64'(bus.bad_count), 64'(bad_exp));

        // Reset while the collector waits for a controller word
        mode       = 2;
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) wait_req("pre_reset");
        @(posedge clk);
        #1;
        check("pre_reset_nonempty", 64'(bus.fifo_empty), 64'd0);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_output_sample", 64'(bus.output_sample), 64'd0);
        check("mid_rst_fifo_empty", 64'(bus.fifo_empty), 64'd1);
        check("mid_rst_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("mid_rst_fifo_data", 64'(bus.fifo_data), 64'd0);
        exp_q.delete();
        for (int i = 0; i < NUM_CH; i++) m_seen[i] = 1'b0;
        bad_exp = 0;
        mode    = 1;
        dir_q   = '{32'h0005_55E7, 32'h0005_55E7, 32'h0006_55E6};
        pop0    = n_pop;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed ch2 words, other channels undriven
        wait_req("restart");
        check("restart_channel", 64'(bus.channel_select), 64'd0);
        for (int i = 1; i < 12; i++) wait_req("directed");
        quiesce();
        drain("directed_drain");
        check("directed_pushes", 64'(n_pop - pop0), 64'd2);
        check("directed_bad_count", 64'(bus.bad_count), 64'd9);

        // Fill past capacity without reads
        mode       = 2;
        bus.enable = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() < DEPTH + 1; i++) wait_req("fill");
        quiesce();
        check("full_fifo_count", 64'(bus.fifo_count), 64'(DEPTH));
        check("full_overflow", 64'(bus.overflow), 64'd1);
        check("full_fifo_empty", 64'(bus.fifo_empty), 64'd0);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        check("full_head", 64'(bus.fifo_data), 64'(exp_q[0]));
        @(negedge clk);
        bus.clear_overflow = 1'b1;
        @(negedge clk);
        bus.clear_overflow = 1'b0;
        #1;
        check("clear_overflow", 64'(bus.overflow), 64'd0);

        // Push and pop in the same cycle while full
        bus.enable = 1'b1;
        wait_req("full_push");
        bus.enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rd_force = 1'b1;
        @(posedge clk);
        #1;
        rd_force = 1'b0;
        check("swap_fifo_count", 64'(bus.fifo_count), 64'(DEPTH));
        check("swap_overflow", 64'(bus.overflow), 64'd0);
        quiesce();
        drain("final_drain");
        check("end_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("end_fifo_data", 64'(bus.fifo_data), 64'd0);
        check("end_fifo_empty", 64'(bus.fifo_empty), 64'd1);
        check("end_overflow", 64'(bus.overflow), 64'd0);
        check("end_bad_count", 64'(bus.bad_count), 64'(bad_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
